// File: rtl/serial_dac_tx.sv
// serial_dac_tx: parallel-to-serial transmitter for an SPI-style DAC.
//   A one-entry holding register takes words through a valid/ready handshake.
//   Each word goes out as one frame: sync_n low, DATA_W bits each DIV clk
//   cycles long, with sclk low in the first half of each bit and high in the
//   second half. A GAP of sync_n high separates consecutive frames.
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   s_data        - parallel sample word (DATA_W bits)
//   s_valid       - s_data valid
//   s_ready       - holding register can accept a word (registered state only)
//   sclk, sdata   - serial bit clock and data to the DAC
//   sync_n        - frame enable, low while a word is shifted
//   busy          - FSM not IDLE
//   underrun      - one-cycle pulse when a frame ends with no word waiting
// All outputs except s_ready are registered copies of values derived from
// the FSM state, so they trail the state register by one clock.
module serial_dac_tx #(
  parameter int DATA_W    = 16,
  parameter int DIV       = 4,
  parameter int LSB_FIRST = 0,
  parameter int GAP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sclk,
  output logic              sdata,
  output logic              sync_n,
  output logic              busy,
  output logic              underrun
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = $clog2(DIV);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                rdy_en_q, rdy_en_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                sync_n_q, sync_n_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;
  logic                accept;
  logic                transfer;

  // rdy_en_q holds s_ready low during reset and releases it on the first edge.
  assign s_ready  = rdy_en_q && !hold_full_q;
  assign accept   = s_valid && s_ready;
  assign sclk     = sclk_q;
  assign sdata    = sdata_q;
  assign sync_n   = sync_n_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rdy_en_d    = 1'b1;
    sclk_d      = 1'b0;
    sdata_d     = 1'b0;
    sync_n_d    = 1'b1;
    busy_d      = (state_q != IDLE);
    underrun_d  = 1'b0;
    transfer    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          transfer = 1'b1;
        end
      end

      SHIFT: begin
        sync_n_d = 1'b0;
        sdata_d  = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_W-1];
        sclk_d   = (div_cnt_q >= DIV_W'(DIV / 2));
        if (div_cnt_q == DIV_W'(DIV - 1)) begin
          div_cnt_d = '0;
          if (LSB_FIRST != 0) shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          else                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      GAP: begin
        // Counts 0..GAP_CYC-1 are the gap proper. With a word waiting, one
        // further count acts as the load cycle that IDLE provides for the
        // first frame, so back-to-back frames see GAP_CYC+1 high cycles.
        if (gap_cnt_q == GAP_W'(GAP_CYC)) begin
          transfer = 1'b1;
        end else if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          if (hold_full_q) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end else begin
            gap_cnt_d  = '0;
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (transfer) begin
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
      div_cnt_d   = '0;
      gap_cnt_d   = '0;
      state_d     = SHIFT;
    end

    if (accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      rdy_en_q    <= 1'b0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sync_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rdy_en_q    <= rdy_en_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      sync_n_q    <= sync_n_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_serial_dac_tx.sv
// Bench for serial_dac_tx: four instances with different parameter sets
// share clk/rst. Words are pushed to a per-lane expected queue when
// accepted; a negedge monitor rebuilds each frame from sdata at sclk rising
// edges and pops/compares on the rising edge of sync_n.
module tb_serial_dac_tx;

  localparam int LW [4] = '{16, 16, 24, 2};
  localparam int LD [4] = '{4, 4, 2, 8};
  localparam int LL [4] = '{0, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sd [4];
  logic        sv [4];
  logic        rdy [4];
  logic        sclk [4];
  logic        sdat [4];
  logic        syncn [4];
  logic        busy [4];
  logic        und [4];

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] expq [4][$];
  int          gapq [$];

  logic        prev_sync [4];
  logic        prev_sclk [4];
  int          flen [4];
  int          nb [4];
  logic [31:0] acc [4];
  int          fs [4];
  int          und_cnt [4];
  int          hi_len [4];
  int          viol [4];

  always #5 clk = ~clk;

  serial_dac_tx #(.DATA_W(16), .DIV(4), .LSB_FIRST(0), .GAP_CYC(2)) u_dut0 (
    .clk(clk), .rst(rst), .s_data(sd[0][15:0]), .s_valid(sv[0]), .s_ready(rdy[0]),
    .sclk(sclk[0]), .sdata(sdat[0]), .sync_n(syncn[0]), .busy(busy[0]), .underrun(und[0]));
  serial_dac_tx #(.DATA_W(16), .DIV(4), .LSB_FIRST(1), .GAP_CYC(2)) u_dut1 (
    .clk(clk), .rst(rst), .s_data(sd[1][15:0]), .s_valid(sv[1]), .s_ready(rdy[1]),
    .sclk(sclk[1]), .sdata(sdat[1]), .sync_n(syncn[1]), .busy(busy[1]), .underrun(und[1]));
  serial_dac_tx #(.DATA_W(24), .DIV(2), .LSB_FIRST(0), .GAP_CYC(2)) u_dut2 (
    .clk(clk), .rst(rst), .s_data(sd[2][23:0]), .s_valid(sv[2]), .s_ready(rdy[2]),
    .sclk(sclk[2]), .sdata(sdat[2]), .sync_n(syncn[2]), .busy(busy[2]), .underrun(und[2]));
  serial_dac_tx #(.DATA_W(2), .DIV(8), .LSB_FIRST(0), .GAP_CYC(2)) u_dut3 (
    .clk(clk), .rst(rst), .s_data(sd[3][1:0]), .s_valid(sv[3]), .s_ready(rdy[3]),
    .sclk(sclk[3]), .sdata(sdat[3]), .sync_n(syncn[3]), .busy(busy[3]), .underrun(und[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lmask(input int l);
    return (32'd1 << LW[l]) - 32'd1;
  endfunction

  task automatic mon_reset();
    for (int l = 0; l < 4; l++) begin
      prev_sync[l] = 1'b1;
      prev_sclk[l] = 1'b0;
      flen[l]      = 0;
      nb[l]        = 0;
      acc[l]       = '0;
      hi_len[l]    = 0;
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++) begin
      sd[l] = '0; sv[l] = 1'b0; fs[l] = 0; und_cnt[l] = 0; viol[l] = 0;
    end
    mon_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_reset();
      end else begin
        for (int l = 0; l < 4; l++) begin
          if (und[l]) und_cnt[l]++;
          if (!syncn[l]) begin
            if (prev_sync[l]) begin
              fs[l]++;
              if (l == 0) gapq.push_back(hi_len[0]);
              flen[l] = 0; nb[l] = 0; acc[l] = '0;
            end
            flen[l]++;
            if (sclk[l] && !prev_sclk[l]) begin
              if (LL[l] != 0) acc[l] = acc[l] | (32'(sdat[l]) << nb[l]);
              else            acc[l] = (acc[l] << 1) | 32'(sdat[l]);
              nb[l]++;
            end
          end else begin
            if (!prev_sync[l]) begin
              chk($sformatf("frame_len%0d", l), flen[l], LW[l] * LD[l]);
              chk($sformatf("frame_bits%0d", l), nb[l], LW[l]);
              if (expq[l].size() == 0) chk($sformatf("frame_unexp%0d", l), 1, 0);
              else chk($sformatf("frame_word%0d", l), acc[l], expq[l].pop_front());
              hi_len[l] = 1;
            end else begin
              hi_len[l]++;
            end
            if (sclk[l] || sdat[l]) viol[l]++;
          end
          prev_sync[l] = syncn[l];
          prev_sclk[l] = sclk[l];
        end
      end
    end
  end

  task automatic send(input int l, input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    sd[l] = w & lmask(l);
    sv[l] = 1'b1;
    #1;
    while (!rdy[l] && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (rdy[l]) begin
      expq[l].push_back(w & lmask(l));
      @(posedge clk); #1;
    end else begin
      chk($sformatf("send_timeout%0d", l), 0, 1);
    end
  endtask

  task automatic drop(input int l);
    sv[l] = 1'b0;
  endtask

  task automatic drain(input int l);
    int n = 0;
    while (!(expq[l].size() == 0 && !busy[l] && syncn[l]) && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("drain%0d", l), (n < 3000), 1);
  endtask

  task automatic wait_low(input int l);
    int n = 0;
    while (syncn[l] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("wait_low%0d", l), syncn[l], 0);
  endtask

  initial begin
    int u0;
    int base;
    int n;
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    int base;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_sync_n", syncn[0], 1);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_sdata", sdat[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_underrun", und[0], 0);
    chk("rst_ready", rdy[0], 0);
    rst = 1'b0;
    @(negedge clk); #1;
    for (int l = 0; l < 4; l++) chk($sformatf("ready_after_rst%0d", l), rdy[l], 1);

    // single word, MSB first, with start latency and underrun
    u0 = und_cnt[0];
    send(0, 32'hA5C3);
    drop(0);
    @(posedge clk); #1;
    chk("lat_e1_sync_n", syncn[0], 1);
    @(posedge clk); #1;
    chk("lat_e2_sync_n", syncn[0], 0);
    chk("lat_busy", busy[0], 1);
    drain(0);
    chk("single_underrun", und_cnt[0] - u0, 1);

    // LSB first
    u0 = und_cnt[1];
    send(1, 32'hA5C3);
    drop(1);
    drain(1);
    chk("lsb_underrun", und_cnt[1] - u0, 1);

    // parameter sweep lanes
    send(2, 32'hABCDEF);
    drop(2);
    drain(2);
    send(3, 32'h2);
    send(3, 32'h1);
    drop(3);
    drain(3);

    // streaming with s_valid held high
    gapq.delete();
    u0 = und_cnt[0];
    send(0, 32'h0001);
    send(0, 32'h8000);
    send(0, 32'hFFFF);
    drop(0);
    drain(0);
    chk("stream_frames", gapq.size(), 3);
    if (gapq.size() == 3) begin
      chk("stream_gap1", gapq[1], 3);
      chk("stream_gap2", gapq[2], 3);
    end
    chk("stream_underrun", und_cnt[0] - u0, 1);

    // backpressure
    u0 = und_cnt[0];
    base = fs[0];
    send(0, 32'h1111);
    drop(0);
    wait_low(0);
    send(0, 32'h2222);
    @(negedge clk); #1;
    chk("bp_ready_low", rdy[0], 0);
    send(0, 32'h3333);
    @(negedge clk); #1;
    chk("bp_third_after_f2", fs[0] - base, 2);
    drop(0);
    drain(0);
    chk("bp_underrun", und_cnt[0] - u0, 1);

    // asynchronous reset mid-frame with a word held
    send(0, 32'hBEEF);
    drop(0);
    wait_low(0);
    send(0, 32'h5555);
    drop(0);
    n = 0;
    while (nb[0] != 7 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("reach_bit7", nb[0], 7);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_sync_n", syncn[0], 1);
    chk("arst_sclk", sclk[0], 0);
    chk("arst_ready", rdy[0], 0);
    chk("arst_underrun", und[0], 0);
    expq[0].delete();
    u0 = und_cnt[0];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("arst_ready_after", rdy[0], 1);
    chk("arst_no_underrun", und_cnt[0] - u0, 0);
    send(0, 32'h1234);
    drop(0);
    drain(0);
    chk("arst_post_underrun", und_cnt[0] - u0, 1);
    chk("idle_busy", busy[0], 0);

    for (int l = 0; l < 4; l++) chk($sformatf("idle_outputs%0d", l), viol[l], 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_dac_tx.md
SERIAL_DAC_TX -- requirements
Module: serial_dac_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample word width (legal 2..32).
REQ-002 SHALL have parameter DIV, default 4, clk cycles per serial bit (even, >=2).
REQ-003 SHALL have parameter LSB_FIRST, default 0, bit order (0 = MSB first, 1 = LSB first).
REQ-004 SHALL have parameter GAP_CYC, default 2, clk cycles with sync_n high between frames (>=1).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port s_data  input  DATA_W  parallel sample word.
REQ-008 SHALL have port s_valid  input  1  s_data valid.
REQ-009 SHALL have port s_ready  output  1  holding register can accept a word.
REQ-010 SHALL have port sclk  output  1  serial bit clock to the DAC.
REQ-011 SHALL have port sdata  output  1  serial data to the DAC.
REQ-012 SHALL have port sync_n  output  1  frame enable, low while a word is being shifted.
REQ-013 SHALL have port busy  output  1  high when the FSM is not IDLE.
REQ-014 SHALL have port underrun  output  1  one-cycle pulse when a frame ends with no word waiting.

Function
REQ-015 Handshake: a word SHALL be accepted on an edge where s_valid && s_ready, and stored in a one-entry holding register.
REQ-016 s_ready SHALL equal !hold_full; hold_full SHALL remain set while s_valid is low, and s_data is ignored when no word is accepted.
REQ-017 The FSM SHALL have the states IDLE, SHIFT and GAP.
REQ-018 IDLE with hold_full: on the next edge, hold SHALL transfer to the shift register and the FSM SHALL enter SHIFT; hold_full clears unless a new word is accepted on the same edge, in which case it stays set with the new word.
REQ-019 A word accepted while IDLE SHALL cause sync_n to go low at the second rising edge after the accepting edge.
REQ-020 SHIFT SHALL last exactly DATA_W*DIV cycles with sync_n=0; bit k (k=0..DATA_W-1) is driven on sdata for DIV consecutive cycles.
REQ-021 Bit order: with LSB_FIRST=0, bit k SHALL be s_data[DATA_W-1-k]; with LSB_FIRST=1, bit k SHALL be s_data[k].
REQ-022 Within each bit period, sclk SHALL be 0 for the first DIV/2 cycles and 1 for the last DIV/2 cycles, so sdata changes only while sclk=0.
REQ-023 After the last bit period, the FSM SHALL enter GAP for exactly GAP_CYC cycles with sync_n=1, sclk=0 and sdata=0.
REQ-024 At the end of GAP: if hold_full, the FSM SHALL perform the REQ-018 transfer directly (frames separated by exactly GAP_CYC+1 high sync_n cycles); otherwise it SHALL return to IDLE and pulse underrun for one cycle.
REQ-025 underrun SHALL NOT pulse on the end of a frame when a word is waiting, nor while IDLE.
REQ-026 In IDLE, outputs SHALL be sclk=0, sdata=0, sync_n=1 and busy=0.
REQ-027 All outputs SHALL be registered with no combinational path from s_valid or s_data to any output; s_ready may depend only on registered state.
REQ-028 Bit and divider counters SHALL be sized by $clog2 of DATA_W and DIV, and SHALL wrap to 0 at each bit or frame boundary without overrun.

Reset
REQ-029 While rst=1, the block SHALL immediately clear FSM=IDLE, hold_full=0, the shift register and counters to 0, sclk=0, sdata=0, sync_n=1, busy=0 and underrun=0.
REQ-030 s_ready SHALL be 1 from the first edge after rst deasserts.
REQ-031 Reset mid-frame SHALL abort the frame with no underrun pulse, and the word in hold SHALL be discarded.

Verification
REQ-032 DATA_W=16, DIV=4, LSB_FIRST=0; one word 0xA5C3 -> sync_n low for 64 cycles; sdata sampled at sclk rising edges gives 1010010111000011; then GAP; then underrun pulses once.
REQ-033 Same word with LSB_FIRST=1 -> sampled sequence 1100001110100101.
REQ-034 s_valid held high with words 0x0001, 0x8000, 0xFFFF -> three frames; sync_n high for exactly GAP_CYC+1=3 cycles between frames; no underrun until after the third frame.
REQ-035 Backpressure: offer a second and third word during frame 1 -> s_ready=0 after the second word is held; the third word is accepted only after frame 2 begins, and no word is lost or duplicated.
REQ-036 Assert rst asynchronously (between edges) at bit 7 of a frame -> sync_n=1, sclk=0 and s_ready=0 without waiting for a clock edge; after release, s_ready=1 and a new word 0x1234 is transmitted correctly.
REQ-037 Parameter sweep DATA_W=24, DIV=2 and DATA_W=2, DIV=8 -> frame length equals DATA_W*DIV cycles and bit order is correct.
